shl_seq: RTL

Sequential logical shift-left unit, the left-shift counterpart of the datapath's combinational shift-right block. It is used where a full barrel shifter is too costly. An operand is captured on a `start` pulse and shifted left one bit per clock, with zero fill, for `min(sh_amt, DATAWIDTH)` cycles. It then presents the result with a one-cycle `done` pulse and an overflow flag that is set if any 1 bit was shifted out.

---
 rtl/shl_seq.sv | 93 +++++++++
 1 files changed

// File: rtl/shl_seq.sv
// Sequential logical shift-left: captures an operand on start, shifts it left
// one bit per clock with zero fill, then reports the result and overflow.
module shl_seq #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] d,
  output logic                 ov
);

  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [DATAWIDTH-1:0] DW_FULL = DATAWIDTH'(DATAWIDTH);
  localparam logic [CW-1:0]        DW_CNT  = CW'(DATAWIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DATAWIDTH-1:0]   work_q, work_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ov_acc_q, ov_acc_d;
  logic [DATAWIDTH-1:0]   d_q, d_d;
  logic                   ov_q, ov_d;
  logic                   done_q, done_d;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      ov_acc_q <= 1'b0;
      d_q      <= '0;
      ov_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      ov_acc_q <= ov_acc_d;
      d_q      <= d_d;
      ov_q     <= ov_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    ov_acc_d = ov_acc_q;
    d_d      = d_q;
    ov_d     = ov_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d   = a;
          // Clamp on the full-width amount so large values saturate at DATAWIDTH
          cnt_d    = (sh_amt >= DW_FULL) ? DW_CNT : sh_amt[CW-1:0];
          ov_acc_d = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          ov_acc_d = ov_acc_q | work_q[DATAWIDTH-1];
          work_d   = {work_q[DATAWIDTH-2:0], 1'b0};
          cnt_d    = cnt_q - CW'(1);
        end else begin
          d_d     = work_q;
          ov_d    = ov_acc_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign d    = d_q;
  assign ov   = ov_q;

endmodule
